// File: rtl/nand_phy_rd_capture.sv
// NAND PHY read-data capture: aligns a burst to a programmed latency, packs {fall, rise} beats
// into words and queues them in a FIFO toward the controller. Optional LFSR checker: NAND_RD_CHECK_EN.
module nand_phy_rd_capture #(
  parameter int DQ_WIDTH   = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int LAT_W      = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  rd_start,
  input  logic [CNT_W-1:0]      rd_len,
  input  logic [LAT_W-1:0]      rd_lat,
  input  logic [DQ_WIDTH-1:0]   rd_data_rise,
  input  logic [DQ_WIDTH-1:0]   rd_data_fall,
  output logic [2*DQ_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  input  logic [2*DQ_WIDTH-1:0] chk_seed,
  output logic [15:0]           err_cnt
);
  localparam int W  = 2 * DQ_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_LAT, CAPTURE, FINISH} state_t;

  state_t             state_q, state_d;
  logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   beat_q, beat_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        cnt_q, cnt_d;
  logic               overflow_q, overflow_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [W:0]         mem_q [FIFO_DEPTH];

  logic [W-1:0]       word;
  logic               last_beat;
  logic               cap;
  logic               pop;
  logic               full;
  logic               wr_en;

  always_comb begin
    word      = {rd_data_fall, rd_data_rise};
    last_beat = (beat_q == len_q - CNT_W'(1));
    cap       = (state_q == CAPTURE);
    pop       = (cnt_q != '0) && out_ready;
    full      = (cnt_q == (AW+1)'(FIFO_DEPTH));
    // A pop in the same cycle frees the head entry, so a full FIFO still accepts the write.
    wr_en     = cap && (!full || pop);

    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    len_d      = len_q;
    beat_d     = beat_q;
    overflow_d = overflow_q;

    case (state_q)
      IDLE: begin
        if (rd_start) begin
          len_d      = rd_len;
          lat_cnt_d  = rd_lat;
          beat_d     = '0;
          overflow_d = 1'b0;
          if (rd_len == '0)      state_d = FINISH;
          else if (rd_lat == '0) state_d = CAPTURE;
          else                   state_d = WAIT_LAT;
        end
      end
      WAIT_LAT: begin
        if (lat_cnt_q == LAT_W'(1)) state_d = CAPTURE;
        else                         lat_cnt_d = lat_cnt_q - LAT_W'(1);
      end
      CAPTURE: begin
        beat_d = beat_q + CNT_W'(1);
        if (!wr_en)    overflow_d = 1'b1;
        if (last_beat) state_d = FINISH;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d   = (state_d != IDLE);
    done_d   = (state_d == FINISH);
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_d    = cnt_q + (AW+1)'(wr_en) - (AW+1)'(pop);
  end

  always_ff @(posedge clk0) begin
    if (rst0) begin
      state_q    <= IDLE;
      lat_cnt_q  <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clk0) begin
    if (wr_en) mem_q[wr_ptr_q] <= {last_beat, word};
  end

  // Head is gated by valid so the outputs read zero while the FIFO is empty.
  assign out_valid = (cnt_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q][W-1:0] : '0;
  assign out_last  = out_valid & mem_q[rd_ptr_q][W];
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = overflow_q;

`ifdef NAND_RD_CHECK_EN
  logic [W-1:0] lfsr_q, lfsr_d;
  logic [15:0]  err_q, err_d;

  // Every captured beat is compared, including beats the FIFO had to drop.
  always_comb begin
    lfsr_d = lfsr_q;
    err_d  = err_q;
    if (state_q == IDLE && rd_start) begin
      lfsr_d = chk_seed;
      err_d  = '0;
    end else if (cap) begin
      lfsr_d = {lfsr_q[W-2:0], lfsr_q[W-1] ^ lfsr_q[W-3] ^ lfsr_q[W-4] ^ lfsr_q[W-6]};
      if (word != lfsr_q && err_q != 16'hFFFF) err_d = err_q + 16'd1;
    end
  end

  always_ff @(posedge clk0) begin
    if (rst0) begin
      lfsr_q <= '0;
      err_q  <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      err_q  <= err_d;
    end
  end

  assign err_cnt = err_q;
`else
  logic unused_chk_seed;
  assign unused_chk_seed = ^chk_seed;
  assign err_cnt         = '0;
`endif

endmodule

// File: tb/tb_nand_phy_rd_capture.sv
// Scoreboard bench for nand_phy_rd_capture: directed bursts push expected words, a monitor pops on handshake.
module tb_nand_phy_rd_capture;
  logic        clk0 = 1'b0;
  logic        rst0;
  logic        rd_start;
  logic [15:0] rd_len;
  logic [3:0]  rd_lat;
  logic [7:0]  rd_data_rise;
  logic [7:0]  rd_data_fall;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [15:0] chk_seed;
  logic [15:0] err_cnt;

  always #5 clk0 = ~clk0;

  nand_phy_rd_capture #(.DQ_WIDTH(8), .FIFO_DEPTH(16), .LAT_W(4), .CNT_W(16)) dut (
    .clk0(clk0), .rst0(rst0), .rd_start(rd_start), .rd_len(rd_len), .rd_lat(rd_lat),
    .rd_data_rise(rd_data_rise), .rd_data_fall(rd_data_fall), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .busy(busy),
    .done(done), .overflow(overflow), .chk_seed(chk_seed), .err_cnt(err_cnt)
  );

  typedef struct packed {
    logic        last;
    logic [15:0] data;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         tests = 0;
  int         fails = 0;
  logic [7:0] br [0:31];
  logic [7:0] bf [0:31];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [15:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  always @(negedge clk0) begin
    if (!rst0 && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got %0h expected no word", out_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_data", {16'h0, out_data}, {16'h0, mon_e.data});
        check("sb_last", {31'h0, out_last}, {31'h0, mon_e.last});
      end
    end
  end

  // Issue one burst; beat b is presented for the edge rd_lat+1+b after the start edge.
  task automatic burst(input int len, input int lat, input logic [15:0] seed,
                       input bit rdy_at0, input bit poke, input int exp_n);
    int n;
    int idx;
    bit seen;
    @(posedge clk0); #2;
    rd_start = 1'b1; rd_len = 16'(len); rd_lat = 4'(lat); chk_seed = seed;
    rd_data_rise = 8'hA5; rd_data_fall = 8'h5A;
    seen = 1'b0;
    n = 0;
    while (!seen && n < lat + len + 6) begin
      @(posedge clk0); #2;
      rd_start = 1'b0;
      if (rdy_at0) out_ready = 1'b1;
      if (poke && n == 1) begin
        rd_start = 1'b1; rd_len = 16'd0; rd_lat = 4'd0;
      end
      idx = n - lat;
      if (idx >= 0 && idx < len) begin
        rd_data_rise = br[idx]; rd_data_fall = bf[idx];
      end else begin
        rd_data_rise = 8'hA5; rd_data_fall = 8'h5A;
      end
      @(negedge clk0);
      if (n == 0) check("busy_rise", {31'h0, busy}, 32'h1);
      if (done) seen = 1'b1;
      else      n++;
    end
    check("done_cycle", seen ? 32'(n) : 32'hFFFF_FFFF, 32'(exp_n));
    @(posedge clk0); #2;
    rd_start = 1'b0;
    @(negedge clk0);
    check("busy_fall", {31'h0, busy}, 32'h0);
    check("done_pulse", {31'h0, done}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcnt;
    logic [15:0] lf;
    logic [15:0] w;
    rst0 = 1'b1; rd_start = 1'b0; rd_len = '0; rd_lat = '0;
    rd_data_rise = '0; rd_data_fall = '0; out_ready = 1'b0; chk_seed = '0;
    repeat (4) @(posedge clk0);
    #2 rst0 = 1'b0;
    @(negedge clk0);
    check("rst_valid", {31'h0, out_valid}, 32'h0);
    check("rst_data", {16'h0, out_data}, 32'h0);
    check("rst_last", {31'h0, out_last}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_overflow", {31'h0, overflow}, 32'h0);
    check("rst_err_cnt", {16'h0, err_cnt}, 32'h0);

    // Main burst, with an rd_start poke mid-burst that must be ignored.
    br[0] = 8'h11; bf[0] = 8'h22; br[1] = 8'h33; bf[1] = 8'h44;
    br[2] = 8'h55; bf[2] = 8'h66; br[3] = 8'h77; bf[3] = 8'h88;
    push(16'h2211, 1'b0); push(16'h4433, 1'b0); push(16'h6655, 1'b0); push(16'h8877, 1'b1);
    out_ready = 1'b1;
    burst(4, 3, 16'h0, 1'b0, 1'b1, 7);

    br[0] = 8'hC3; bf[0] = 8'h3C;
    push(16'h3CC3, 1'b1);
    burst(1, 0, 16'h0, 1'b0, 1'b0, 1);

    burst(0, 2, 16'h0, 1'b0, 1'b0, 0);

    // Overflow: 20 beats into 16 entries with no consumer.
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      br[i] = 8'(i); bf[i] = 8'(8'h80 | i);
      if (i < 16) push({8'(8'h80 | i), 8'(i)}, 1'b0);
    end
    burst(20, 2, 16'h0, 1'b0, 1'b0, 22);
    check("overflow_set", {31'h0, overflow}, 32'h1);
    check("full_valid", {31'h0, out_valid}, 32'h1);

    // Write on a full FIFO in the same cycle as a pop must be kept.
    br[0] = 8'hEE; bf[0] = 8'hDD;
    push(16'hDDEE, 1'b1);
    burst(1, 0, 16'h0, 1'b1, 1'b0, 1);
    check("overflow_clear", {31'h0, overflow}, 32'h0);
    repeat (24) @(negedge clk0);
    check("drain_empty", 32'(exp_q.size()), 32'h0);

    // Reset asserted on the edge that would capture beat 2.
    out_ready = 1'b0;
    @(posedge clk0); #2;
    rd_start = 1'b1; rd_len = 16'd8; rd_lat = 4'd0;
    @(posedge clk0); #2 rd_start = 1'b0;
    @(posedge clk0);
    @(posedge clk0); #2 rst0 = 1'b1;
    @(posedge clk0); #2 rst0 = 1'b0;
    @(negedge clk0);
    check("abort_valid", {31'h0, out_valid}, 32'h0);
    check("abort_busy", {31'h0, busy}, 32'h0);
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) dcnt++;
      @(negedge clk0);
    end
    check("abort_no_done", 32'(dcnt), 32'h0);

    // Checker: LFSR sequence from 0xACE1 with beat 5 corrupted.
    out_ready = 1'b1;
    lf = 16'hACE1;
    for (int i = 0; i < 8; i++) begin
      w = (i == 5) ? (lf ^ 16'h0100) : lf;
      br[i] = w[7:0]; bf[i] = w[15:8];
      push(w, i == 7);
      lf = lfsr_next(lf);
    end
    burst(8, 1, 16'hACE1, 1'b0, 1'b0, 9);
`ifdef NAND_RD_CHECK_EN
    check("err_cnt", {16'h0, err_cnt}, 32'h1);
`else
    check("err_cnt", {16'h0, err_cnt}, 32'h0);
`endif
    repeat (6) @(negedge clk0);
    check("final_empty", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
